// File: rtl/gs_instr_encoder.sv
// gs_instr_encoder
// Accepts one encode request at a time, checks the immediate against the
// chosen RV32 format, packs the 32-bit instruction word and writes it to
// instruction memory at an auto-incrementing byte address. Rejected requests
// produce a one-cycle error pulse and leave the address and count untouched.

module gs_instr_encoder (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [31:0] i_base_addr,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [2:0]  i_req_fmt,
    input  logic [4:0]  i_req_opcode,
    input  logic [2:0]  i_req_funct3,
    input  logic [6:0]  i_req_funct7,
    input  logic [4:0]  i_req_rd,
    input  logic [4:0]  i_req_rs1,
    input  logic [4:0]  i_req_rs2,
    input  logic [31:0] i_req_imm,
    output logic        o_imem_we,
    input  logic        i_imem_ready,
    output logic [31:0] o_imem_addr,
    output logic [31:0] o_imem_wdata,
    output logic        o_err_valid,
    output logic [1:0]  o_err_code,
    output logic [15:0] o_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENC   = 2'd1,
        S_WRITE = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_FMT   = 2'd1;
    localparam logic [1:0] ERR_RANGE = 2'd2;
    localparam logic [1:0] ERR_ALIGN = 2'd3;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_ready_en;
    logic [2:0]  r_fmt;
    logic [4:0]  r_opcode;
    logic [2:0]  r_funct3;
    logic [6:0]  r_funct7;
    logic [4:0]  r_rd;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [31:0] r_imm;
    logic [31:0] r_addr;
    logic [15:0] r_count;
    logic [31:0] r_wdata;
    logic [1:0]  r_err_code;

    logic        w_handshake;
    logic        w_sx11;
    logic        w_sx12;
    logic        w_sx20;
    logic [31:0] w_word;
    logic [1:0]  w_err;

    // The ready enable holds off acceptance until the first edge after reset.
    assign o_req_ready  = r_ready_en & (r_state == S_IDLE) & ~i_start;
    assign w_handshake  = i_req_valid & o_req_ready;

    // Sign-extension checks: the immediate fits when all upper bits agree.
    assign w_sx11 = (&r_imm[31:11]) | ~(|r_imm[31:11]);
    assign w_sx12 = (&r_imm[31:12]) | ~(|r_imm[31:12]);
    assign w_sx20 = (&r_imm[31:20]) | ~(|r_imm[31:20]);

    assign o_imem_we    = (r_state == S_WRITE);
    assign o_imem_addr  = r_addr;
    assign o_imem_wdata = r_wdata;
    assign o_err_valid  = (r_state == S_ERR);
    assign o_err_code   = (r_state == S_ERR) ? r_err_code : ERR_NONE;
    assign o_count      = r_count;

    // Pack the captured request into an instruction word and grade the immediate.
    always_comb begin
        w_word = 32'h0000_0000;
        w_err  = ERR_NONE;
        case (r_fmt)
            FMT_R: begin
                w_word = {r_funct7, r_rs2, r_rs1, r_funct3, r_rd, r_opcode, 2'b11};
            end
            FMT_I: begin
                w_word = {r_imm[11:0], r_rs1, r_funct3, r_rd, r_opcode, 2'b11};
                if (!w_sx11) w_err = ERR_RANGE;
            end
            FMT_S: begin
                w_word = {r_imm[11:5], r_rs2, r_rs1, r_funct3, r_imm[4:0], r_opcode, 2'b11};
                if (!w_sx11) w_err = ERR_RANGE;
            end
            FMT_B: begin
                w_word = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, r_funct3,
                          r_imm[4:1], r_imm[11], r_opcode, 2'b11};
                if (!w_sx12)       w_err = ERR_RANGE;
                else if (r_imm[0]) w_err = ERR_ALIGN;
            end
            FMT_U: begin
                w_word = {r_imm[31:12], r_rd, r_opcode, 2'b11};
                if (r_imm[11:0] != 12'h000) w_err = ERR_RANGE;
            end
            FMT_J: begin
                w_word = {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12],
                          r_rd, r_opcode, 2'b11};
                if (!w_sx20)       w_err = ERR_RANGE;
                else if (r_imm[0]) w_err = ERR_ALIGN;
            end
            default: begin
                w_err = ERR_FMT;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    // Next-state logic: accept, encode, then either write or flag an error.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_handshake) w_next_state = S_ENC;
            S_ENC:   w_next_state = (w_err == ERR_NONE) ? S_WRITE : S_ERR;
            S_WRITE: if (i_imem_ready) w_next_state = S_IDLE;
            S_ERR:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Capture request fields on handshake and arm ready after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ready_en <= 1'b0;
            r_fmt      <= 3'd0;
            r_opcode   <= 5'd0;
            r_funct3   <= 3'd0;
            r_funct7   <= 7'd0;
            r_rd       <= 5'd0;
            r_rs1      <= 5'd0;
            r_rs2      <= 5'd0;
            r_imm      <= 32'd0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_handshake) begin
                r_fmt    <= i_req_fmt;
                r_opcode <= i_req_opcode;
                r_funct3 <= i_req_funct3;
                r_funct7 <= i_req_funct7;
                r_rd     <= i_req_rd;
                r_rs1    <= i_req_rs1;
                r_rs2    <= i_req_rs2;
                r_imm    <= i_req_imm;
            end
        end
    end

    // Write pointer, word count, and the registered word/error from encode.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr     <= 32'd0;
            r_count    <= 16'd0;
            r_wdata    <= 32'd0;
            r_err_code <= ERR_NONE;
        end else begin
            if (r_state == S_IDLE && i_start) begin
                r_addr  <= i_base_addr;
                r_count <= 16'd0;
            end else if (r_state == S_WRITE && i_imem_ready) begin
                r_addr  <= r_addr + 32'd4;
                r_count <= r_count + 16'd1;
            end
            if (r_state == S_ENC) begin
                r_err_code <= w_err;
                if (w_err == ERR_NONE) r_wdata <= w_word;
            end
        end
    end

endmodule
